// File: rtl/sid_pkg.sv
// sid_pkg: shared widths, coefficient constants and the filter register bundle for the SID filter stage.
// Build option SID_FILTER_SAT_EN is consumed by sid_svf_core; nothing here depends on it.
package sid_pkg;

  localparam int VOICE_W  = 12;
  localparam int OUT_W    = 16;
  localparam int FC_W     = 11;
  localparam int RES_W    = 4;
  localparam int VOL_W    = 4;
  localparam int NVOICE   = 3;
  localparam int FC_OFS   = 32;
  localparam int RES_STEP = 12;
  localparam int COEF_F_W = 16;
  localparam int COEF_Q_W = 9;
  localparam int F_FRAC   = 16;
  localparam int Q_FRAC   = 8;
  localparam logic [OUT_W-1:0] MID_OUT = 16'h8000;

  typedef struct packed {
    logic [FC_W-1:0]   fc;
    logic [RES_W-1:0]  res;
    logic [NVOICE-1:0] filt;
    logic              off3;
    logic              hp;
    logic              bp;
    logic              lp;
    logic [VOL_W-1:0]  vol;
  } filter_t;

  // Cutoff coefficient in Q0.16: the offset keeps the filter from stalling at fc=0.
  function automatic logic [COEF_F_W-1:0] calcF(input logic [FC_W-1:0] fc);
    return COEF_F_W'((int'(fc) + FC_OFS) << 3);
  endfunction

  function automatic logic [COEF_Q_W-1:0] calcQ(input logic [RES_W-1:0] res);
    return COEF_Q_W'(256 - RES_STEP * int'(res));
  endfunction

endpackage

// File: rtl/sid_svf_core.sv
// sid_svf_core: Chamberlin state-variable integrator pair; lp/bp are the registered state, hp is combinational.
// Build option SID_FILTER_SAT_EN: state and hp saturate to the SW-bit range instead of wrapping.
module sid_svf_core
  #(
    parameter int SW = 24
  ) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic                         clk_en,
    input  logic signed [SW-1:0]         x,
    input  logic [sid_pkg::COEF_F_W-1:0] f,
    input  logic [sid_pkg::COEF_Q_W-1:0] q,
    output logic signed [SW-1:0]         hp,
    output logic signed [SW-1:0]         bp,
    output logic signed [SW-1:0]         lp
  );
  import sid_pkg::*;

  // Headroom for a full-scale state times a 17-bit signed coefficient.
  localparam int WW = SW + 20;

`ifdef SID_FILTER_SAT_EN
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  function automatic logic signed [SW-1:0] fitState(input logic signed [WW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[SW-1:0];
    if (v < SAT_MIN) return SAT_MIN[SW-1:0];
    return SW'(v);
  endfunction
`else
  function automatic logic signed [SW-1:0] fitState(input logic signed [WW-1:0] v);
    return SW'(v);
  endfunction
`endif

  logic signed [SW-1:0] r_lp;
  logic signed [SW-1:0] r_bp;

  logic signed [COEF_F_W:0] w_fS;
  logic signed [COEF_Q_W:0] w_qS;
  logic signed [WW-1:0]     w_qbp;
  logic signed [WW-1:0]     w_hpFull;
  logic signed [WW-1:0]     w_bpFull;
  logic signed [WW-1:0]     w_lpFull;
  logic signed [SW-1:0]     w_hp;
  logic signed [SW-1:0]     w_bpNext;
  logic signed [SW-1:0]     w_lpNext;

  assign w_fS = $signed({1'b0, f});
  assign w_qS = $signed({1'b0, q});

  // Both integrators read the pre-update bp, so lp lags bp by one sample.
  always_comb begin
    w_qbp    = (WW'(r_bp) * WW'(w_qS)) >>> Q_FRAC;
    w_hpFull = WW'(x) - WW'(r_lp) - w_qbp;
    w_hp     = fitState(w_hpFull);
    w_bpFull = WW'(r_bp) + ((WW'(w_hp) * WW'(w_fS)) >>> F_FRAC);
    w_lpFull = WW'(r_lp) + ((WW'(r_bp) * WW'(w_fS)) >>> F_FRAC);
    w_bpNext = fitState(w_bpFull);
    w_lpNext = fitState(w_lpFull);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_lp <= '0;
      r_bp <= '0;
    end else if (clk_en) begin
      r_lp <= w_lpNext;
      r_bp <= w_bpNext;
    end
  end

  assign hp = w_hp;
  assign bp = r_bp;
  assign lp = r_lp;

endmodule

// File: rtl/sid_filter_core.sv
// sid_filter_core: SID filter/mixer -- voice routing, SVF, mode mix, master volume, offset-binary output.
// Build option SID_FILTER_SAT_EN selects saturating SVF state (inside sid_svf_core); output clamp is always on.
module sid_filter_core
  #(
    parameter int FRAC = 6,
    parameter int SW   = 24
  ) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      clk_en,
    input  logic [sid_pkg::VOICE_W-1:0] v_0,
    input  logic [sid_pkg::VOICE_W-1:0] v_1,
    input  logic [sid_pkg::VOICE_W-1:0] v_2,
    input  logic [sid_pkg::FC_W-1:0]    reg_fc,
    input  logic [sid_pkg::RES_W-1:0]   reg_res,
    input  logic [sid_pkg::NVOICE-1:0]  reg_en,
    input  logic                      reg_off3,
    input  logic                      reg_hp,
    input  logic                      reg_bp,
    input  logic                      reg_lp,
    input  logic [sid_pkg::VOL_W-1:0]   reg_vol,
    output logic [sid_pkg::OUT_W-1:0]   audio_out
  );
  import sid_pkg::*;

  localparam int SUM_W = VOICE_W + 3;
  localparam int MIX_W = 32;
  localparam logic signed [MIX_W-1:0] O_MAX = 32'sh0000_7FFF;
  localparam logic signed [MIX_W-1:0] O_MIN = 32'shFFFF_8000;

  filter_t                    w_regs;
  logic signed [VOICE_W-1:0]  w_s [NVOICE];
  logic signed [SUM_W-1:0]    w_fin;
  logic signed [SUM_W-1:0]    w_dir;
  logic signed [SW-1:0]       w_x;
  logic [COEF_F_W-1:0]        w_f;
  logic [COEF_Q_W-1:0]        w_q;
  logic signed [SW-1:0]       w_hp;
  logic signed [SW-1:0]       w_bp;
  logic signed [SW-1:0]       w_lp;
  logic signed [VOL_W:0]      w_volS;
  logic signed [MIX_W-1:0]    w_mix;
  logic signed [MIX_W-1:0]    w_scaled;
  logic signed [OUT_W-1:0]    w_o;
  logic [OUT_W-1:0]           w_audioNext;
  logic [OUT_W-1:0]           r_audio;

  assign w_regs = '{fc: reg_fc, res: reg_res, filt: reg_en, off3: reg_off3,
                    hp: reg_hp, bp: reg_bp, lp: reg_lp, vol: reg_vol};

  // Offset-binary to two's complement is just an MSB flip around the 0x800 midpoint.
  assign w_s[0] = {~v_0[VOICE_W-1], v_0[VOICE_W-2:0]};
  assign w_s[1] = {~v_1[VOICE_W-1], v_1[VOICE_W-2:0]};
  assign w_s[2] = {~v_2[VOICE_W-1], v_2[VOICE_W-2:0]};

  always_comb begin
    w_fin = '0;
    w_dir = '0;
    for (int i = 0; i < NVOICE; i++) begin
      if (w_regs.filt[i]) begin
        w_fin = w_fin + SUM_W'(w_s[i]);
      end else if (!((i == NVOICE - 1) && w_regs.off3)) begin
        w_dir = w_dir + SUM_W'(w_s[i]);
      end
    end
  end

  assign w_x = SW'(w_fin) <<< FRAC;
  assign w_f = calcF(w_regs.fc);
  assign w_q = calcQ(w_regs.res);

  sid_svf_core #(
    .SW (SW)
  ) u_svf (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .x       (w_x),
    .f       (w_f),
    .q       (w_q),
    .hp      (w_hp),
    .bp      (w_bp),
    .lp      (w_lp)
  );

  assign w_volS = $signed({1'b0, w_regs.vol});

  // Mode outputs are taken from the pre-update state, dropped back to voice scale.
  always_comb begin
    w_mix = MIX_W'(w_dir);
    if (w_regs.lp) w_mix = w_mix + MIX_W'(w_lp >>> FRAC);
    if (w_regs.bp) w_mix = w_mix + MIX_W'(w_bp >>> FRAC);
    if (w_regs.hp) w_mix = w_mix + MIX_W'(w_hp >>> FRAC);
    w_scaled = (w_mix * MIX_W'(w_volS)) >>> 2;
    if (w_scaled > O_MAX) begin
      w_o = 16'sh7FFF;
    end else if (w_scaled < O_MIN) begin
      w_o = 16'sh8000;
    end else begin
      w_o = OUT_W'(w_scaled);
    end
    w_audioNext = {~w_o[OUT_W-1], w_o[OUT_W-2:0]};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_audio <= MID_OUT;
    end else if (clk_en) begin
      r_audio <= w_audioNext;
    end
  end

  assign audio_out = r_audio;

endmodule

// File: tb/tb_sid_filter_core.sv
// tb_sid_filter_core: directed stimulus for the SID filter stage, checked every cycle against an integer model.
// Honours SID_FILTER_SAT_EN in the model the same way the design build does.
module tb_sid_filter_core;

  logic        clk = 1'b0;
  logic        nReset = 1'b1;
  logic        clkEn = 1'b0;
  logic [11:0] v0 = 12'h800;
  logic [11:0] v1 = 12'h800;
  logic [11:0] v2 = 12'h800;
  logic [10:0] regFc = '0;
  logic [3:0]  regRes = '0;
  logic [2:0]  regEn = '0;
  logic        regOff3 = 1'b0;
  logic        regHp = 1'b0;
  logic        regBp = 1'b0;
  logic        regLp = 1'b0;
  logic [3:0]  regVol = '0;
  logic [15:0] audioOut;

  int nChecks = 0;
  int nFails = 0;

  longint      mLp = 0;
  longint      mBp = 0;
  logic [15:0] mAudio = 16'h8000;

  always #5 clk = ~clk;

  sid_filter_core dut (
    .clk       (clk),
    .n_reset   (nReset),
    .clk_en    (clkEn),
    .v_0       (v0),
    .v_1       (v1),
    .v_2       (v2),
    .reg_fc    (regFc),
    .reg_res   (regRes),
    .reg_en    (regEn),
    .reg_off3  (regOff3),
    .reg_hp    (regHp),
    .reg_bp    (regBp),
    .reg_lp    (regLp),
    .reg_vol   (regVol),
    .audio_out (audioOut)
  );

  // 24-bit state arithmetic: either saturate or wrap, matching the build option.
  function automatic longint fitState(input longint v);
`ifdef SID_FILTER_SAT_EN
    if (v > 64'sd8388607) return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
`else
    longint w;
    w = v & 64'h0000_0000_00FF_FFFF;
    if (w >= 64'sd8388608) w = w - 64'sd16777216;
    return w;
`endif
  endfunction

  function automatic void modelStep(output longint nLp, output longint nBp, output logic [15:0] nAudio);
    longint vv [3];
    longint s, fin, dir, f, q, x, hp, mix, o;
    vv[0] = longint'(v0);
    vv[1] = longint'(v1);
    vv[2] = longint'(v2);
    fin = 0;
    dir = 0;
    for (int i = 0; i < 3; i++) begin
      s = vv[i] - 2048;
      if (regEn[i]) fin = fin + s;
      else if (!(i == 2 && regOff3)) dir = dir + s;
    end
    f = (longint'(regFc) + 32) * 8;
    q = 256 - 12 * longint'(regRes);
    x = fin * 64;
    hp = fitState(x - mLp - ((q * mBp) >>> 8));
    nBp = fitState(mBp + ((f * hp) >>> 16));
    nLp = fitState(mLp + ((f * mBp) >>> 16));
    mix = dir + (regLp ? (mLp >>> 6) : 0) + (regBp ? (mBp >>> 6) : 0) + (regHp ? (hp >>> 6) : 0);
    o = (mix * longint'(regVol)) >>> 2;
    if (o > 32767) o = 32767;
    if (o < -32768) o = -32768;
    nAudio = 16'(o + 32768);
  endfunction

  always @(posedge clk or negedge nReset) begin
    longint nLp, nBp;
    logic [15:0] nAudio;
    if (!nReset) begin
      mLp <= 0;
      mBp <= 0;
      mAudio <= 16'h8000;
    end else if (clkEn) begin
      modelStep(nLp, nBp, nAudio);
      mLp <= nLp;
      mBp <= nBp;
      mAudio <= nAudio;
    end
  end

  // Model comparison on every falling edge, well away from the sampling edge.
  always @(negedge clk) begin
    nChecks++;
    if (audioOut !== mAudio) begin
      nFails++;
      $display("[TB] FAIL model_compare t=%0t audio_out=%h expected=%h", $time, audioOut, mAudio);
    end
  end

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    nChecks++;
    if (actual < lo || actual > hi) begin
      nFails++;
      $display("[TB] FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expected, input int tol);
    checkRange(name, int'(audioOut), int'(expected) - tol, int'(expected) + tol);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
    end
  endtask

  task automatic pulseReset(input string name);
    @(negedge clk);
    #2 nReset = 1'b0;
    #1 checkOutput(name, 16'h8000, 0);
    @(negedge clk);
    #2 nReset = 1'b1;
  endtask

  task automatic ringRun(input logic [3:0] res, output int downCross, output int minOut);
    int cur;
    bit prevAbove;
    pulseReset("ring_reset");
    regEn = 3'b001; regLp = 1'b0; regHp = 1'b0; regBp = 1'b1;
    regFc = 11'd256; regRes = res; regVol = 4'd15; regOff3 = 1'b0;
    v0 = 12'hFFF; v1 = 12'h800; v2 = 12'h800;
    downCross = 0;
    minOut = 0;
    prevAbove = 1'b0;
    for (int i = 0; i < 700; i++) begin
      applyStimulus(1);
      cur = int'(audioOut) - 32768;
      if (cur < minOut) minOut = cur;
      if (cur < 0 && prevAbove) downCross++;
      if (cur != 0) prevAbove = (cur > 0);
    end
  endtask

  initial begin
    int cross15, min15, cross0, min0;
    $display("[TB] start");
    #1 nReset = 1'b0;
    applyStimulus(4);
    checkOutput("reset_state", 16'h8000, 0);
    @(negedge clk);
    #2 nReset = 1'b1;
    applyStimulus(3);
    checkOutput("idle_midpoint", 16'h8000, 0);

    // Direct path: 2047*15>>2 = 7676, 2047>>2 = 511, -2048>>2 = -512, -2048*15>>2 = -7680.
    v0 = 12'hFFF; regVol = 4'd15;
    applyStimulus(1); checkOutput("direct_v0_vol15", 16'h9DFC, 0);
    regVol = 4'd1;
    applyStimulus(1); checkOutput("direct_v0_vol1", 16'h81FF, 0);
    v0 = 12'h000;
    applyStimulus(1); checkOutput("direct_neg_vol1", 16'h7E00, 0);
    regVol = 4'd15;
    applyStimulus(1); checkOutput("direct_neg_vol15", 16'h6200, 0);
    regVol = 4'd0;
    applyStimulus(1); checkOutput("vol_zero", 16'h8000, 0);

    v0 = 12'h800; v2 = 12'hFFF; regVol = 4'd15; regOff3 = 1'b1;
    applyStimulus(1); checkOutput("off3_mutes_v2", 16'h8000, 0);
    regOff3 = 1'b0;
    applyStimulus(1); checkOutput("off3_clear_v2", 16'h9DFC, 0);

    regEn = 3'b100; regOff3 = 1'b1; regFc = 11'd2047; regRes = 4'd0;
    applyStimulus(5); checkOutput("filtered_no_mode", 16'h8000, 0);
    // Truncating integrators settle up to 6 state LSBs under x: one output step (4 LSB) low.
    regLp = 1'b1;
    applyStimulus(200); checkOutput("lp_settle_v2", 16'h9DFA, 2);

    pulseReset("pre_v0_reset");
    v2 = 12'h800; v0 = 12'hFFF; regEn = 3'b001; regOff3 = 1'b0;
    applyStimulus(200); checkOutput("lp_settle_v0", 16'h9DFA, 2);
    regLp = 1'b0; regHp = 1'b1;
    applyStimulus(5); checkOutput("hp_settle_v0", 16'h8000, 2);

    // A q=1 bandpass still undershoots once, shallowly; resonance makes repeated deep swings.
    ringRun(4'd15, cross15, min15);
    checkRange("ring_res15_crossings", cross15, 2, 1000);
    checkRange("ring_res15_depth", min15, -40000, -2049);
    ringRun(4'd0, cross0, min0);
    checkRange("ring_res0_depth", min0, -2048, 0);

    regBp = 1'b0; regHp = 1'b0; regLp = 1'b1; regRes = 4'd0; regFc = 11'd2047;
    applyStimulus(100); checkOutput("lp_large_before_reset", 16'h9DFA, 2);
    pulseReset("reset_pulse_immediate");
    // From lp=bp=0: hp=x gives 0x9DFC; then bp=33247 -> 519 -> 0x879A; then bp=58057 -> 907 -> 0x8D49.
    regLp = 1'b0; regHp = 1'b1;
    applyStimulus(1); checkOutput("post_reset_hp", 16'h9DFC, 0);
    regHp = 1'b0; regBp = 1'b1;
    applyStimulus(1); checkOutput("post_reset_bp1", 16'h879A, 0);
    repeat (30) @(negedge clk);
    checkOutput("freeze_hold", 16'h879A, 0);
    applyStimulus(1); checkOutput("post_freeze_bp2", 16'h8D49, 0);

    applyStimulus(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
